// File: rtl/uart_imem_loader_if.sv
// UART byte stream in, instruction RAM write port and CPU control out.
// The loader is the slave; the bench or SoC side is the master.
interface uart_imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        cpu_rst_req;
   logic        done;
   logic        err;

   modport slave (
      input  rx_data,
      input  rx_valid,
      output imem_we,
      output imem_addr,
      output imem_wdata,
      output cpu_hold,
      output cpu_rst_req,
      output done,
      output err
   );

   modport master (
      output rx_data,
      output rx_valid,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata,
      input  cpu_hold,
      input  cpu_rst_req,
      input  done,
      input  err
   );
endinterface

// File: rtl/uart_imem_loader.sv
// Frame parser that assembles big-endian words from UART bytes
// and writes them to instruction RAM while holding the CPU.
module uart_imem_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
   parameter int          MAX_WORDS      = 1024,
   parameter int          TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
   input logic               clk,
   input logic               reset,
   uart_imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   // Counter only needs to reach TIMEOUT_CYCLES-1 before expiry.
   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]   MAXW     = 32'(MAX_WORDS);

   state_t        state;
   logic [7:0]    len_hi;
   logic [15:0]   len;
   logic [15:0]   idx;
   logic [1:0]    nbyte;
   logic [23:0]   wbuf;
   logic [7:0]    csum;
   logic [TW-1:0] tmo;

   logic [15:0] n_rx;
   logic        in_frame;
   logic        len_ok;
   logic        hdr_hit;

   // Decode the length candidate and frame-activity flags.
   always_comb begin
      n_rx     = {len_hi, bus.rx_data};
      len_ok   = (n_rx != 16'd0) && ({16'd0, n_rx} <= MAXW);
      hdr_hit  = bus.rx_valid && (bus.rx_data == HDR_BYTE);
      in_frame = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_CSUM);
   end

   // Frame FSM with registered RAM-write and CPU-control outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         len_hi          <= '0;
         len             <= '0;
         idx             <= '0;
         nbyte           <= '0;
         wbuf            <= '0;
         csum            <= '0;
         tmo             <= '0;
         bus.imem_we     <= 1'b0;
         bus.imem_addr   <= BASE_ADDR;
         bus.imem_wdata  <= '0;
         bus.cpu_hold    <= 1'b0;
         bus.cpu_rst_req <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
      end else begin
         bus.imem_we     <= 1'b0;
         bus.cpu_rst_req <= 1'b0;

         // Inter-byte watchdog; an arriving byte always wins.
         if (in_frame) begin
            if (bus.rx_valid) begin
               tmo <= '0;
            end else if (tmo == TMO_LAST) begin
               state        <= S_ERROR;
               bus.err      <= 1'b1;
               bus.cpu_hold <= 1'b1;
               nbyte        <= '0;
               tmo          <= '0;
            end else begin
               tmo <= tmo + 1'b1;
            end
         end

         unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (hdr_hit) begin
                  state        <= S_LEN_HI;
                  bus.done     <= 1'b0;
                  bus.err      <= 1'b0;
                  bus.cpu_hold <= 1'b1;
                  idx          <= '0;
                  nbyte        <= '0;
                  csum         <= '0;
                  tmo          <= '0;
               end
            end
            S_LEN_HI: begin
               if (bus.rx_valid) begin
                  len_hi <= bus.rx_data;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (bus.rx_valid) begin
                  len <= n_rx;
                  if (len_ok) begin
                     state <= S_DATA;
                  end else begin
                     state   <= S_ERROR;
                     bus.err <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (bus.rx_valid) begin
                  csum <= csum + bus.rx_data;
                  if (nbyte == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_addr  <=
                        BASE_ADDR + {14'd0, idx, 2'b00};
                     bus.imem_wdata <= {wbuf, bus.rx_data};
                     idx            <= idx + 16'd1;
                     nbyte          <= '0;
                     if (idx == len - 16'd1)
                        state <= S_CSUM;
                  end else begin
                     wbuf  <= {wbuf[15:0], bus.rx_data};
                     nbyte <= nbyte + 2'd1;
                  end
               end
            end
            S_CSUM: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data == csum) begin
                     state           <= S_DONE;
                     bus.done        <= 1'b1;
                     bus.cpu_rst_req <= 1'b1;
                     bus.cpu_hold    <= 1'b0;
                  end else begin
                     state   <= S_ERROR;
                     bus.err <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
